dma_burst_device: RTL
=====================

Name: dma_burst_device

Overview:
- Synthesizable, clocked successor to the DMA test-bench external device.
- Holds NUM_BLOCKS blocks of WORDS_PER_BLOCK words, refilled from an internal LFSR.
- Raises a programmable sequence of interrupts and serves registered block reads to the DMA controller.
- Sits beside the cached CPU/DMA subsystem and replaces delay-based timing with cycle-counted timing, an ack handshake, and error/miss reporting.

Parameters:
- WORD_SIZE, 16: bits per word (1..32).
- WORDS_PER_BLOCK, 4: words returned per read.
- NUM_BLOCKS, 3: valid blocks (1..2^OFFSET_BITS).
- OFFSET_BITS, 2: offset width.
- FIRE_DELAY, 1700: countdown cycles before the first interrupt.
- REFIRE_DELAY, 300: countdown cycles before each later interrupt.
- INT_DURATION, 10: maximum interrupt-high cycles without ack.
- HOLD_CYCLES, 64: cycles storage is frozen after the interrupt ends.
- NUM_FIRES, 2: total interrupts, then idle forever.
- LFSR_SEED, 16'hACE1: LFSR reset value (must be nonzero).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  0 freezes the FSM and all counters; reads are still served.
- ack  in  1  DMA acknowledge; ends the interrupt early.
- rd_en  in  1  read request, sampled each cycle.
- offset  in  OFFSET_BITS  block index for the read.
- data  out  WORDS_PER_BLOCK*WORD_SIZE  block read data.
- data_valid  out  1  one-cycle pulse, read accepted.
- rd_err  out  1  one-cycle pulse, read rejected.
- interrupt  out  1  transfer request to the CPU.
- int_missed  out  1  sticky: an interrupt expired without ack.
- fire_count  out  8  interrupts raised so far.
- done  out  1  all NUM_FIRES interrupts completed.

Behaviour:
- Reset (async assert, sync release) outputs: data=0, data_valid=0, rd_err=0, interrupt=0, int_missed=0, fire_count=0, done=0.
- Reset internal state: LFSR=LFSR_SEED, state=FILL, fill index=0.
- LFSR: 16-bit Galois, one step per FILL cycle. next = (s>>1) ^ (s[0] ? 16'hB400 : 0).
- Fill word value: low WORD_SIZE bits of {next,next}.
- Fill order: one word per cycle, block0 word0, block0 word1, and so on, NUM_BLOCKS*WORDS_PER_BLOCK cycles total.
- Word w of a block occupies data[w*WORD_SIZE +: WORD_SIZE].
- FILL: on the last word, go to COUNT, loading FIRE_DELAY if fire_count==0, else REFIRE_DELAY.
- COUNT: decrement each enabled cycle. At 1, go to ASSERT.
- ASSERT: interrupt=1 from the cycle after entry. fire_count increments on entry.
- ASSERT exit: ack=1 for one cycle, or INT_DURATION cycles elapsed. Timeout sets int_missed. Either exit goes to HOLD with interrupt=0 on the next edge.
- ack seen on the same edge ASSERT is entered: honoured, interrupt pulses exactly one cycle.
- ack outside ASSERT is ignored.
- HOLD: HOLD_CYCLES cycles, then DONE if fire_count==NUM_FIRES, else FILL. The LFSR continues from its current state and is not reseeded.
- DONE: done=1, terminal until reset.
- Reads are registered with 1-cycle latency. rd_en at edge N produces data/data_valid valid after edge N+1.
- Read accepted (offset<NUM_BLOCKS and state≠FILL): data = that block, data_valid pulses.
- Read rejected (offset≥NUM_BLOCKS, or state==FILL): rd_err pulses and data retains its previous value; the output is never driven to Z.
- Back-to-back reads are allowed every cycle.
- enable=0 holds state, counters and LFSR; reads are unaffected. An interrupt already high stays high, and its duration counter pauses.
- Reset mid-ASSERT: interrupt drops asynchronously. The full sequence restarts from FILL with the seed.
- NUM_FIRES=0: go straight from the first FILL to DONE, and no interrupt is ever raised.

Test Plan:
- Defaults, LFSR_SEED=16'hACE1. After the 12-cycle fill, read offset 0 → data[15:0]=16'hE270, data[31:16]=16'h7138, data_valid one cycle after rd_en.
- FIRE_DELAY=10, INT_DURATION=4, no ack:
  - interrupt rises exactly 10 cycles after FILL completes and is high for 4 cycles.
  - int_missed=1, fire_count=1.
- ack asserted on the 2nd interrupt-high cycle → interrupt low on the next edge, int_missed stays 0, HOLD begins.
- Read with offset=3 (NUM_BLOCKS=3) → rd_err pulses, data unchanged. Any read during FILL → rd_err=1, data_valid=0.
- NUM_FIRES=2, REFIRE_DELAY=5, HOLD_CYCLES=8, full run:
  - exactly two interrupts, second block contents differ from the first.
  - fire_count=2, then done=1 permanently.
- Toggles and resets:
  - enable=0 for 20 cycles during COUNT delays the interrupt by exactly 20 cycles.
  - reset_n low mid-ASSERT zeroes interrupt immediately.
  - after release, data re-fills to the same first word 16'hE270.

Source files
------------

// File: rtl/dma_burst_device.sv
// DMA burst test device: LFSR-filled block storage, cycle-counted interrupt sequence
// with ack/timeout handling, and a registered one-cycle-latency block read port.
module dma_burst_device #(
   parameter int          WORD_SIZE       = 16,
   parameter int          WORDS_PER_BLOCK = 4,
   parameter int          NUM_BLOCKS      = 3,
   parameter int          OFFSET_BITS     = 2,
   parameter int          FIRE_DELAY      = 1700,
   parameter int          REFIRE_DELAY    = 300,
   parameter int          INT_DURATION    = 10,
   parameter int          HOLD_CYCLES     = 64,
   parameter int          NUM_FIRES       = 2,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 enable,
   input  logic                                 ack,
   input  logic                                 rd_en,
   input  logic [OFFSET_BITS-1:0]               offset,
   output logic [WORDS_PER_BLOCK*WORD_SIZE-1:0] data,
   output logic                                 data_valid,
   output logic                                 rd_err,
   output logic                                 interrupt,
   output logic                                 int_missed,
   output logic [7:0]                           fire_count,
   output logic                                 done
);

   localparam int BLOCK_W = WORDS_PER_BLOCK * WORD_SIZE;
   localparam int WIW     = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAXC = max_of(max_of(FIRE_DELAY, REFIRE_DELAY), max_of(INT_DURATION, HOLD_CYCLES));
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [OFFSET_BITS:0] NB_LIMIT = (OFFSET_BITS+1)'(NUM_BLOCKS);

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [WORD_SIZE-1:0] fill_word(input logic [15:0] s);
      logic [31:0] dbl_v;
      dbl_v = {s, s};
      return dbl_v[WORD_SIZE-1:0];
   endfunction

   typedef enum logic [2:0] {
      S_FILL   = 3'd0,
      S_COUNT  = 3'd1,
      S_ASSERT = 3'd2,
      S_HOLD   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                 state_r, state_nx_s;
   logic [CW-1:0]          cnt_r, cnt_nx_s;
   logic [15:0]            lfsr_r, lfsr_nx_s;
   logic [OFFSET_BITS-1:0] fill_blk_r;
   logic [WIW-1:0]         fill_wrd_r;
   logic [BLOCK_W-1:0]     mem_r [NUM_BLOCKS];
   logic                   wrd_last_s, blk_last_s, fill_last_s;
   logic                   ack_pend_r, ack_pend_nx_s, ack_s;
   logic                   int_nx_s, done_nx_s, fire_inc_s, miss_s;
   logic                   interrupt_r, int_missed_r, done_r;
   logic [7:0]             fire_count_r;
   logic [BLOCK_W-1:0]     data_r;
   logic                   data_valid_r, rd_err_r, rd_ok_s;

   assign lfsr_nx_s   = lfsr_step(lfsr_r);
   assign wrd_last_s  = (fill_wrd_r == WIW'(WORDS_PER_BLOCK - 1));
   assign blk_last_s  = (fill_blk_r == OFFSET_BITS'(NUM_BLOCKS - 1));
   assign fill_last_s = wrd_last_s && blk_last_s;
   // An ack that coincides with the entry edge is remembered and honoured one cycle later.
   assign ack_s       = ack || ack_pend_r;
   assign rd_ok_s     = ({1'b0, offset} < NB_LIMIT) && (state_r != S_FILL);

   // FSM state and the shared countdown register (delay, interrupt duration, hold).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= S_FILL;
         cnt_r   <= CW'(0);
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
      end
   end

   // Next state and next countdown value; everything holds while enable is low.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      if (enable) begin
         case (state_r)
            S_FILL: begin
               if (fill_last_s) begin
                  state_nx_s = (NUM_FIRES == 0) ? S_DONE : S_COUNT;
                  cnt_nx_s   = (fire_count_r == 8'd0) ? CW'(FIRE_DELAY) : CW'(REFIRE_DELAY);
               end else begin
                  state_nx_s = S_FILL;
               end
            end
            S_COUNT: begin
               if (cnt_r == CW'(1)) begin
                  state_nx_s = S_ASSERT;
                  cnt_nx_s   = CW'(INT_DURATION);
               end else begin
                  cnt_nx_s = cnt_r - CW'(1);
               end
            end
            S_ASSERT: begin
               if (ack_s || (cnt_r == CW'(1))) begin
                  state_nx_s = S_HOLD;
                  cnt_nx_s   = CW'(HOLD_CYCLES);
               end else begin
                  cnt_nx_s = cnt_r - CW'(1);
               end
            end
            S_HOLD: begin
               if (cnt_r == CW'(1)) begin
                  state_nx_s = (fire_count_r == 8'(NUM_FIRES)) ? S_DONE : S_FILL;
               end else begin
                  state_nx_s = S_HOLD;
               end
               cnt_nx_s = cnt_r - CW'(1);
            end
            S_DONE:  state_nx_s = S_DONE;
            default: state_nx_s = S_FILL;
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // Next values of the registered status outputs, derived from the transition.
   always_comb begin
      int_nx_s   = (state_nx_s == S_ASSERT);
      done_nx_s  = (state_nx_s == S_DONE);
      fire_inc_s = (state_r != S_ASSERT) && (state_nx_s == S_ASSERT);
      miss_s     = (state_r == S_ASSERT) && (state_nx_s == S_HOLD) && !ack_s;
      if (fire_inc_s) begin
         ack_pend_nx_s = ack;
      end else if (enable) begin
         ack_pend_nx_s = 1'b0;
      end else begin
         ack_pend_nx_s = ack_pend_r;
      end
   end

   // Status output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         interrupt_r  <= 1'b0;
         int_missed_r <= 1'b0;
         done_r       <= 1'b0;
         fire_count_r <= 8'd0;
         ack_pend_r   <= 1'b0;
      end else begin
         interrupt_r  <= int_nx_s;
         done_r       <= done_nx_s;
         ack_pend_r   <= ack_pend_nx_s;
         int_missed_r <= int_missed_r || miss_s;
         fire_count_r <= fire_inc_s ? (fire_count_r + 8'd1) : fire_count_r;
      end
   end

   // Storage fill: one LFSR step and one word written per enabled FILL cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_r     <= LFSR_SEED;
         fill_blk_r <= {OFFSET_BITS{1'b0}};
         fill_wrd_r <= {WIW{1'b0}};
         for (int b = 0; b < NUM_BLOCKS; b++) begin
            mem_r[b] <= {BLOCK_W{1'b0}};
         end
      end else if (enable && (state_r == S_FILL)) begin
         lfsr_r <= lfsr_nx_s;
         mem_r[fill_blk_r][fill_wrd_r*WORD_SIZE +: WORD_SIZE] <= fill_word(lfsr_nx_s);
         if (wrd_last_s) begin
            fill_wrd_r <= {WIW{1'b0}};
            fill_blk_r <= blk_last_s ? {OFFSET_BITS{1'b0}} : (fill_blk_r + {{(OFFSET_BITS-1){1'b0}}, 1'b1});
         end else begin
            fill_wrd_r <= fill_wrd_r + {{(WIW-1){1'b0}}, 1'b1};
         end
      end
   end

   // Read port: data only changes on an accepted read, independent of enable.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_r       <= {BLOCK_W{1'b0}};
         data_valid_r <= 1'b0;
         rd_err_r     <= 1'b0;
      end else begin
         data_valid_r <= rd_en && rd_ok_s;
         rd_err_r     <= rd_en && !rd_ok_s;
         if (rd_en && rd_ok_s) begin
            data_r <= mem_r[offset];
         end
      end
   end

   assign data       = data_r;
   assign data_valid = data_valid_r;
   assign rd_err     = rd_err_r;
   assign interrupt  = interrupt_r;
   assign int_missed = int_missed_r;
   assign fire_count = fire_count_r;
   assign done       = done_r;

endmodule
